buzzer_scheduler: RTL and testbench

Sequencing and arbitration controller for the shared piezo buzzer path. Accepts play requests from the alarm comparator, the countdown timer and keypad click logic, and grants the buzzer to one source at a time by fixed priority with preemption. Steps a note index into the melody ROM at a fixed note rate, and handles looping, ring timeout, snooze and dismissal. Sits between the clock/alarm/timer logic and the melody ROM + tone generator, which consume `src`, `note_idx` and `tone_en`.

---
 rtl/buzzer_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_buzzer_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_scheduler
//  Purpose  : Arbitrates the shared piezo buzzer between the alarm, countdown
//             timer and keypad click sources (fixed priority, preemptive),
//             steps the melody ROM note index at a fixed note rate, and
//             handles looping, ring timeout, snooze and dismissal.
//  Ports    : clk_i, reset_i     - clock, synchronous active-high reset
//             sec_tick_i         - one-cycle pulse per second
//             alarm_req_i        - alarm time match pulse
//             timer_req_i        - countdown expiry pulse
//             key_req_i          - keypress pulse
//             stop_i, snooze_i   - user dismiss / snooze pulses
//             src_o              - owner: 0 idle, 1 key, 2 timer, 3 alarm
//             note_idx_o         - melody ROM index for src_o
//             tone_en_o          - buzzer enable (src_o != 0)
//             snoozing_o         - snooze countdown armed
//             done_o             - one-cycle pulse when a play ends
//  Revision : 1.0 - initial release
// ============================================================================
module buzzer_scheduler #(
   parameter int unsigned STEP_CYCLES = 500000,
   parameter int unsigned ALARM_LEN   = 54,
   parameter int unsigned TIMER_LEN   = 16,
   parameter int unsigned KEY_LEN     = 2,
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       sec_tick_i,
   input  logic       alarm_req_i,
   input  logic       timer_req_i,
   input  logic       key_req_i,
   input  logic       stop_i,
   input  logic       snooze_i,
   output logic [1:0] src_o,
   output logic [7:0] note_idx_o,
   output logic       tone_en_o,
   output logic       snoozing_o,
   output logic       done_o
);

   localparam int unsigned       STEP_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
   localparam logic [7:0]        ALARM_LAST  = 8'(ALARM_LEN - 1);
   localparam logic [7:0]        TIMER_LAST  = 8'(TIMER_LEN - 1);
   localparam logic [7:0]        KEY_LAST    = 8'(KEY_LEN - 1);
   localparam logic [8:0]        RING_LAST   = 9'(RING_SECS - 1);
   localparam logic [8:0]        SNOOZE_LOAD = 9'(SNOOZE_SECS);

   localparam logic [1:0] SRC_IDLE  = 2'd0;
   localparam logic [1:0] SRC_KEY   = 2'd1;
   localparam logic [1:0] SRC_TIMER = 2'd2;
   localparam logic [1:0] SRC_ALARM = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        src_q, src_d;
   logic [7:0]        note_q, note_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [8:0]        ring_q, ring_d;
   logic              pend_q, pend_d;
   logic              snoozing_q, snoozing_d;
   logic [8:0]        snz_cnt_q, snz_cnt_d;
   logic              tone_q, tone_d;
   logic              done_q, done_d;

   logic              w_snz_exp;
   logic              w_alarm;
   logic [1:0]        w_top;
   logic              w_grant;
   logic [1:0]        w_grant_src;
   logic              w_end;

   // Snooze expiry is the tick that takes the counter to zero; a same-cycle
   // stop suppresses it so no alarm is raised.
   assign w_snz_exp = snoozing_q & sec_tick_i & (snz_cnt_q <= 9'd1) & ~stop_i;
   assign w_alarm   = alarm_req_i | w_snz_exp;
   assign w_top     = w_alarm     ? SRC_ALARM :
                      timer_req_i ? SRC_TIMER :
                      key_req_i   ? SRC_KEY   : SRC_IDLE;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      note_d      = note_q;
      step_d      = step_q;
      ring_d      = ring_q;
      pend_d      = pend_q;
      snoozing_d  = snoozing_q;
      snz_cnt_d   = snz_cnt_q;
      done_d      = 1'b0;
      w_grant     = 1'b0;
      w_grant_src = SRC_IDLE;
      w_end       = 1'b0;

      if (stop_i) begin
         // Dismiss overrides every same-cycle request, snooze and expiry.
         done_d     = (state_q == ST_PLAY);
         state_d    = ST_IDLE;
         src_d      = SRC_IDLE;
         note_d     = 8'd0;
         step_d     = '0;
         ring_d     = 9'd0;
         pend_d     = 1'b0;
         snoozing_d = 1'b0;
         snz_cnt_d  = 9'd0;
      end else begin
         if (snoozing_q && sec_tick_i) begin
            if (w_snz_exp) begin
               snoozing_d = 1'b0;
               snz_cnt_d  = 9'd0;
            end else begin
               snz_cnt_d = snz_cnt_q - 9'd1;
            end
         end

         // src_q is 0 in IDLE, so a plain compare covers both idle grant and
         // preemption of a lower-priority owner.
         if (w_top > src_q) begin
            w_grant     = 1'b1;
            w_grant_src = w_top;
            if (src_q == SRC_TIMER || (w_top == SRC_ALARM && timer_req_i)) begin
               pend_d = 1'b1;
            end
         end else if (w_top == SRC_KEY && src_q == SRC_KEY) begin
            w_grant     = 1'b1;
            w_grant_src = SRC_KEY;
         end else if (state_q == ST_PLAY) begin
            if (timer_req_i && src_q == SRC_ALARM) begin
               pend_d = 1'b1;
            end
            if (snooze_i && src_q == SRC_ALARM) begin
               w_end      = 1'b1;
               snoozing_d = 1'b1;
               snz_cnt_d  = SNOOZE_LOAD;
            end
            if (src_q == SRC_KEY && step_q == STEP_LAST && note_q == KEY_LAST) begin
               w_end = 1'b1;
            end
            if (src_q[1] && sec_tick_i && ring_q == RING_LAST) begin
               w_end = 1'b1;
            end

            if (w_end) begin
               done_d = 1'b1;
               if (pend_d) begin
                  pend_d      = 1'b0;
                  w_grant     = 1'b1;
                  w_grant_src = SRC_TIMER;
               end else begin
                  state_d = ST_IDLE;
                  src_d   = SRC_IDLE;
                  note_d  = 8'd0;
                  step_d  = '0;
                  ring_d  = 9'd0;
               end
            end else begin
               if (sec_tick_i && src_q[1]) begin
                  ring_d = ring_q + 9'd1;
               end
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  if ((src_q == SRC_ALARM && note_q == ALARM_LAST) ||
                      (src_q == SRC_TIMER && note_q == TIMER_LAST)) begin
                     note_d = 8'd0;
                  end else begin
                     note_d = note_q + 8'd1;
                  end
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end

         if (w_grant) begin
            state_d = ST_PLAY;
            src_d   = w_grant_src;
            note_d  = 8'd0;
            step_d  = '0;
            ring_d  = 9'd0;
         end
      end

      tone_d = (src_d != SRC_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         src_q      <= SRC_IDLE;
         note_q     <= 8'd0;
         step_q     <= '0;
         ring_q     <= 9'd0;
         pend_q     <= 1'b0;
         snoozing_q <= 1'b0;
         snz_cnt_q  <= 9'd0;
         tone_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         note_q     <= note_d;
         step_q     <= step_d;
         ring_q     <= ring_d;
         pend_q     <= pend_d;
         snoozing_q <= snoozing_d;
         snz_cnt_q  <= snz_cnt_d;
         tone_q     <= tone_d;
         done_q     <= done_d;
      end
   end

   assign src_o      = src_q;
   assign note_idx_o = note_q;
   assign tone_en_o  = tone_q;
   assign snoozing_o = snoozing_q;
   assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buzzer_scheduler
//  Purpose  : Self-checking bench for buzzer_scheduler: vector table, directed
//             multi-cycle sequences and random stimulus against a cycle-count
//             based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_scheduler;

   localparam int STEP   = 4;
   localparam int ALEN   = 6;
   localparam int TLEN   = 3;
   localparam int KLEN   = 2;
   localparam int RING   = 5;
   localparam int SNOOZE = 3;

   // stimulus bit positions: {alarm, timer, key, stop, snooze, tick}
   localparam logic [5:0] IN_A  = 6'b100000;
   localparam logic [5:0] IN_T  = 6'b010000;
   localparam logic [5:0] IN_K  = 6'b001000;
   localparam logic [5:0] IN_S  = 6'b000100;
   localparam logic [5:0] IN_Z  = 6'b000010;
   localparam logic [5:0] IN_TK = 6'b000001;
   localparam logic [5:0] IN_0  = 6'b000000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sec_tick = 1'b0, alarm_req = 1'b0, timer_req = 1'b0, key_req = 1'b0;
   logic       stop = 1'b0, snooze = 1'b0;
   logic [1:0] src;
   logic [7:0] note_idx;
   logic       tone_en, snoozing, done;

   int checks = 0;
   int failures = 0;

   buzzer_scheduler #(
      .STEP_CYCLES(STEP), .ALARM_LEN(ALEN), .TIMER_LEN(TLEN),
      .KEY_LEN(KLEN), .RING_SECS(RING), .SNOOZE_SECS(SNOOZE)
   ) dut (
      .clk_i(clk), .reset_i(reset), .sec_tick_i(sec_tick),
      .alarm_req_i(alarm_req), .timer_req_i(timer_req), .key_req_i(key_req),
      .stop_i(stop), .snooze_i(snooze),
      .src_o(src), .note_idx_o(note_idx), .tone_en_o(tone_en),
      .snoozing_o(snoozing), .done_o(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (elapsed-cycle based) -----------------
   int m_src = 0, m_cyc = 0, m_secs = 0, m_snzleft = 0;
   bit m_pend = 0, m_snoozing = 0, m_done = 0;

   function automatic int len_of(input int s);
      return (s == 3) ? ALEN : (s == 2) ? TLEN : KLEN;
   endfunction

   function automatic int m_note();
      return (m_src == 0) ? 0 : (m_cyc / STEP) % len_of(m_src);
   endfunction

   task automatic m_start(input int s);
      m_src = s; m_cyc = 0; m_secs = 0;
   endtask

   task automatic model_step(input logic [5:0] in, input bit rst);
      bit a, t, k, s, z, tk, expd, ended;
      int req;
      {a, t, k, s, z, tk} = in;
      if (rst) begin
         m_src = 0; m_cyc = 0; m_secs = 0; m_snzleft = 0;
         m_pend = 0; m_snoozing = 0; m_done = 0;
         return;
      end
      m_done = 0;
      if (s) begin
         m_done = (m_src != 0);
         m_src = 0; m_pend = 0; m_snoozing = 0;
         return;
      end
      expd = 0;
      if (m_snoozing && tk) begin
         if (m_snzleft <= 1) begin expd = 1; m_snoozing = 0; end
         else m_snzleft--;
      end
      req = (a || expd) ? 3 : t ? 2 : k ? 1 : 0;
      if (req > m_src) begin
         if (m_src == 2 || (req == 3 && t)) m_pend = 1;
         m_start(req);
      end else if (req == 1 && m_src == 1) begin
         m_start(1);
      end else if (m_src != 0) begin
         ended = 0;
         if (t && m_src == 3) m_pend = 1;
         m_cyc++;
         if (tk && m_src >= 2) m_secs++;
         if (z && m_src == 3) begin ended = 1; m_snoozing = 1; m_snzleft = SNOOZE; end
         if (m_src == 1 && m_cyc >= STEP * KLEN) ended = 1;
         if (m_src >= 2 && m_secs >= RING) ended = 1;
         if (ended) begin
            m_done = 1;
            if (m_pend) begin m_pend = 0; m_start(2); end
            else m_src = 0;
         end
      end
   endtask

   // ---------------- drive / check helpers ---------------------------------
   task automatic check_model();
      logic [12:0] act, exp;
      act = {src, note_idx, tone_en, snoozing, done};
      exp = {2'(m_src), 8'(m_note()), (m_src != 0), m_snoozing, m_done};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL model t=%0t: actual src=%0d note=%0d tone=%0b snz=%0b done=%0b required src=%0d note=%0d tone=%0b snz=%0b done=%0b",
                  $time, act[12:11], act[10:3], act[2], act[1], act[0],
                  exp[12:11], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic step(input logic [5:0] in, input bit rst);
      {alarm_req, timer_req, key_req, stop, snooze, sec_tick} = in;
      reset = rst;
      @(posedge clk);
      model_step(in, rst);
      #1;
      {alarm_req, timer_req, key_req, stop, snooze, sec_tick} = IN_0;
      reset = 1'b0;
      check_model();
   endtask

   task automatic expect_out(input string name, input logic [1:0] e_src, input logic [7:0] e_note,
                             input logic e_tone, input logic e_snz, input logic e_done);
      checks++;
      if ({src, note_idx, tone_en, snoozing, done} !== {e_src, e_note, e_tone, e_snz, e_done}) begin
         failures++;
         $display("FAIL %s: actual src=%0d note=%0d tone=%0b snz=%0b done=%0b required src=%0d note=%0d tone=%0b snz=%0b done=%0b",
                  name, src, note_idx, tone_en, snoozing, done, e_src, e_note, e_tone, e_snz, e_done);
      end
   endtask

   typedef struct {
      logic [5:0] in;
      logic [1:0] e_src;
      logic [7:0] e_note;
      logic       e_tone;
      logic       e_snz;
      logic       e_done;
   } vec_t;

   vec_t tbl[25];

   initial begin
      // key click, simultaneous requests, stop interactions, pend via timeout
      tbl[0]  = '{IN_K, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{IN_0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{IN_0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{IN_0, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{IN_0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{IN_0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{IN_0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{IN_0, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{IN_0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{IN_0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{IN_A | IN_T | IN_K, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{IN_S, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{IN_0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{IN_A | IN_S, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{IN_T, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{IN_A, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{IN_S, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{IN_0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{IN_A | IN_T | IN_K, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[19] = '{IN_TK, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[20] = '{IN_TK, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[21] = '{IN_TK, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
      tbl[22] = '{IN_TK, 2'd3, 8'd1, 1'b1, 1'b0, 1'b0};
      tbl[23] = '{IN_TK, 2'd2, 8'd0, 1'b1, 1'b0, 1'b1};
      tbl[24] = '{IN_S, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1};

      #1;
      step(IN_0, 1'b1);
      step(IN_A | IN_K, 1'b1);
      expect_out("reset_state", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].in, 1'b0);
         expect_out($sformatf("vec%0d", i), tbl[i].e_src, tbl[i].e_note,
                    tbl[i].e_tone, tbl[i].e_snz, tbl[i].e_done);
      end

      // alarm loops through the melody, then times out on the 5th second
      step(IN_A, 1'b0);
      expect_out("alarm_grant", 2'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= 24; j++) begin
         step(IN_0, 1'b0);
         if (j == 23) expect_out("alarm_note5", 2'd3, 8'd5, 1'b1, 1'b0, 1'b0);
         if (j == 24) expect_out("alarm_wrap", 2'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      end
      for (int j = 0; j < 4; j++) step(IN_TK, 1'b0);
      expect_out("alarm_4ticks", 2'd3, 8'd1, 1'b1, 1'b0, 1'b0);
      step(IN_TK, 1'b0);
      expect_out("alarm_timeout", 2'd0, 8'd0, 1'b0, 1'b0, 1'b1);

      // timer preempted by alarm, resumes after alarm timeout
      step(IN_T, 1'b0);
      step(IN_0, 1'b0);
      step(IN_0, 1'b0);
      step(IN_A, 1'b0);
      expect_out("preempt_timer", 2'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) step(IN_TK, 1'b0);
      expect_out("timer_resume", 2'd2, 8'd0, 1'b1, 1'b0, 1'b1);
      step(IN_S, 1'b0);
      expect_out("timer_stop", 2'd0, 8'd0, 1'b0, 1'b0, 1'b1);

      // snooze, timer plays during snooze, expiry replays alarm
      step(IN_A, 1'b0);
      step(IN_Z, 1'b0);
      expect_out("snooze_end", 2'd0, 8'd0, 1'b0, 1'b1, 1'b1);
      step(IN_TK, 1'b0);
      step(IN_T, 1'b0);
      expect_out("timer_in_snooze", 2'd2, 8'd0, 1'b1, 1'b1, 1'b0);
      step(IN_TK, 1'b0);
      step(IN_TK, 1'b0);
      expect_out("snooze_expiry", 2'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      step(IN_Z, 1'b0);
      expect_out("snooze_pend_timer", 2'd2, 8'd0, 1'b1, 1'b1, 1'b1);
      step(IN_S, 1'b0);
      expect_out("stop_in_snooze", 2'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 4; j++) step(IN_TK, 1'b0);
      expect_out("no_replay", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // reset mid-alarm while snoozing
      step(IN_A, 1'b0);
      step(IN_Z, 1'b0);
      step(IN_A, 1'b0);
      expect_out("alarm_while_snz", 2'd3, 8'd0, 1'b1, 1'b1, 1'b0);
      step(IN_0, 1'b0);
      step(IN_0, 1'b1);
      expect_out("mid_reset", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) step(IN_TK, 1'b0);
      expect_out("post_reset_quiet", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // random stimulus against the model
      for (int n = 0; n < 4000; n++) begin
         logic [5:0] in;
         bit rst;
         in = IN_0;
         if ($urandom_range(39) == 0) in |= IN_A;
         if ($urandom_range(29) == 0) in |= IN_T;
         if ($urandom_range(14) == 0) in |= IN_K;
         if ($urandom_range(59) == 0) in |= IN_S;
         if ($urandom_range(19) == 0) in |= IN_Z;
         if ($urandom_range(5)  == 0) in |= IN_TK;
         rst = ($urandom_range(799) == 0);
         step(in, rst);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
